// File: rtl/ins_ram_mp.sv
// ins_ram_mp -- shared instruction memory for the multicore processor.
//
// One memory array serves NUM_PORTS core fetch ports plus a single loader
// write port. Core reads are arbitrated round-robin and each granted read
// returns its word one cycle later. The loader write always wins: a cycle
// with wr_en=1 grants no read and leaves the round-robin pointer alone.
// The array itself is read asynchronously at a registered address.
//
// Optional feature macro: INS_RAM_PARITY_EN
//   defined   : each word carries a parity bit (array is WIDTH+1 wide),
//               wr_perr_inject flips the stored bit, rd_perr reports a
//               mismatch while rd_valid is set.
//   undefined : array is WIDTH wide, rd_perr = 0, wr_perr_inject ignored.
//
// Ports:
//   clk            clock, all logic on the rising edge
//   rstN           synchronous active-low reset
//   wr_en          loader write strobe
//   wr_addr        loader write address (dropped when >= DEPTH)
//   wr_data        loader write data
//   wr_perr_inject invert stored parity for this write (parity build only)
//   rd_req         per-port read request, held until granted
//   rd_addr        per-port read address, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_gnt         one-hot combinational grant
//   rd_valid       one-hot, high the cycle after the grant
//   rd_data        shared read data bus
//   rd_perr        parity error, qualified by rd_valid

package details;
  typedef enum logic {no, yes} mem_init_t;
endpackage

module ins_ram_mp #(
  parameter details::mem_init_t mem_init = details::no,
  parameter string MEM_FILE   = "ins_mem.txt",
  parameter int    WIDTH      = 8,
  parameter int    DEPTH      = 256,
  parameter int    NUM_PORTS  = 2,
  parameter int    ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic                            rstN,
  input  logic                            wr_en,
  input  logic [ADDR_WIDTH-1:0]           wr_addr,
  input  logic [WIDTH-1:0]                wr_data,
  input  logic                            wr_perr_inject,
  input  logic [NUM_PORTS-1:0]            rd_req,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_PORTS-1:0]            rd_gnt,
  output logic [NUM_PORTS-1:0]            rd_valid,
  output logic [WIDTH-1:0]                rd_data,
  output logic                            rd_perr
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
`ifdef INS_RAM_PARITY_EN
  localparam int MEM_W = WIDTH + 1;
`else
  localparam int MEM_W = WIDTH;
`endif
  // One extra bit so the range check also works when DEPTH is a power of two.
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  logic [MEM_W-1:0]      mem_q [DEPTH];
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [NUM_PORTS-1:0]  valid_q, valid_d;
  logic [NUM_PORTS-1:0]  gnt;
  logic [ADDR_WIDTH-1:0] port_addr [NUM_PORTS];
  logic [PTR_W-1:0]      scan_idx;
  logic                  found;
  logic [MEM_W-1:0]      wr_word;
  logic [MEM_W-1:0]      rd_word;
  logic                  wr_in_range;
  logic                  rd_in_range;

  // Unpack the flat address bus into one address per port.
  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port_addr
      assign port_addr[gi] = rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    end
  endgenerate

  assign wr_in_range = {1'b0, wr_addr} < DEPTH_L;
  assign rd_in_range = {1'b0, addr_q} < DEPTH_L;

`ifdef INS_RAM_PARITY_EN
  assign wr_word = {(^wr_data) ^ wr_perr_inject, wr_data};
`else
  logic unused_perr_inject;
  assign wr_word            = wr_data;
  assign unused_perr_inject = wr_perr_inject;
`endif

  // Memory write: no reset, contents survive rstN.
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) begin
      mem_q[wr_addr] <= wr_word;
    end
  end

  // Round-robin arbiter: scan from rr_ptr, first requester wins.
  always_comb begin
    gnt      = '0;
    found    = 1'b0;
    scan_idx = '0;
    rr_ptr_d = rr_ptr_q;
    addr_d   = addr_q;
    if (rstN && !wr_en) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        scan_idx = PTR_W'((int'(rr_ptr_q) + i) % NUM_PORTS);
        if (!found && rd_req[scan_idx]) begin
          found         = 1'b1;
          gnt[scan_idx] = 1'b1;
          addr_d        = port_addr[scan_idx];
          rr_ptr_d      = (scan_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : scan_idx + 1'b1;
        end
      end
    end
    valid_d = gnt;
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      rr_ptr_q <= '0;
      addr_q   <= '0;
      valid_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
    end
  end

  // Asynchronous array read at the registered address; out-of-range reads
  // return an all-zero word, which also has clean parity.
  assign rd_word  = rd_in_range ? mem_q[addr_q] : '0;
  assign rd_data  = rd_word[WIDTH-1:0];
  assign rd_gnt   = gnt;
  assign rd_valid = valid_q;

`ifdef INS_RAM_PARITY_EN
  // XOR over data plus stored bit is 1 exactly when they disagree.
  assign rd_perr = (|valid_q) & (^rd_word);
`else
  assign rd_perr = 1'b0;
`endif

endmodule

// File: tb/tb_ins_ram_mp.sv
// Testbench for ins_ram_mp: directed table of vectors followed by a random
// phase, all compared against a behavioural memory/arbiter model.
module tb_ins_ram_mp;

  localparam int W  = 8;
  localparam int D  = 200;
  localparam int N  = 2;
  localparam int AW = 8;
`ifdef INS_RAM_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic            clk;
  logic            rstN;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [W-1:0]    wr_data;
  logic            wr_perr_inject;
  logic [N-1:0]    rd_req;
  logic [N*AW-1:0] rd_addr;
  logic [N-1:0]    rd_gnt;
  logic [N-1:0]    rd_valid;
  logic [W-1:0]    rd_data;
  logic            rd_perr;

  ins_ram_mp #(
    .WIDTH(W), .DEPTH(D), .NUM_PORTS(N)
  ) dut (
    .clk(clk), .rstN(rstN), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_perr_inject(wr_perr_inject),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_perr(rd_perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         rst_n;
    bit         wr;
    logic [7:0] waddr;
    logic [7:0] wdata;
    bit         inj;
    logic [1:0] req;
    logic [7:0] a0;
    logic [7:0] a1;
    logic [1:0] e_gnt;
    logic [1:0] e_valid;
    bit         chk_data;
    logic [7:0] e_data;
    bit         e_perr;
  } vec_t;

  // Reference model state
  logic [7:0] m_mem [D];
  bit         m_known [D];
  bit         m_inj [D];
  int         m_rr;
  int         m_pend;
  int         m_addr;

  int cyc;
  int pass_cnt;
  int total_cnt;

  vec_t vecs [31];

  function automatic vec_t mk(bit rst_n, bit wr, int waddr, int wdata, bit inj,
                              int req, int a0, int a1, int eg, int ev,
                              bit cd, int ed, bit ep);
    vec_t v;
    v.rst_n = rst_n;  v.wr = wr;  v.waddr = 8'(waddr);  v.wdata = 8'(wdata);
    v.inj = inj;  v.req = 2'(req);  v.a0 = 8'(a0);  v.a1 = 8'(a1);
    v.e_gnt = 2'(eg);  v.e_valid = 2'(ev);  v.chk_data = cd;
    v.e_data = 8'(ed);  v.e_perr = ep;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  // One clock cycle: drive inputs, compare outputs against the model (and
  // optionally the table row), then advance the model past the edge.
  task automatic step(input vec_t v, input bit tbl);
    int         g;
    int         ra [2];
    logic [1:0] eg, ev;
    logic [7:0] ed;
    bit         ep, dk;
    @(negedge clk);
    rstN = v.rst_n;  wr_en = v.wr;  wr_addr = v.waddr;  wr_data = v.wdata;
    wr_perr_inject = v.inj;  rd_req = v.req;  rd_addr = {v.a1, v.a0};
    #1;
    ra[0] = v.a0;  ra[1] = v.a1;
    g = -1;
    if (v.rst_n && !v.wr) begin
      for (int k = 0; k < N; k++) begin
        int p;
        p = (m_rr + k) % N;
        if (g < 0 && v.req[p]) g = p;
      end
    end
    eg = (g >= 0) ? 2'(1 << g) : 2'b00;
    ev = (m_pend >= 0) ? 2'(1 << m_pend) : 2'b00;
    dk = (m_addr >= D) || m_known[m_addr];
    ed = (m_addr >= D) ? 8'h00 : m_mem[m_addr];
    ep = PAR_EN && (m_pend >= 0) && (m_addr < D) && m_inj[m_addr];
    $display("cyc %0d rstN=%0b wr=%0b wa=%0d wd=%h req=%b a0=%0d a1=%0d | gnt=%b valid=%b data=%h perr=%0b",
             cyc, v.rst_n, v.wr, v.waddr, v.wdata, v.req, v.a0, v.a1,
             rd_gnt, rd_valid, rd_data, rd_perr);
    check("rd_gnt", rd_gnt, eg);
    check("rd_valid", rd_valid, ev);
    check("rd_perr", rd_perr, ep);
    if (dk) check("rd_data", rd_data, ed);
    if (tbl) begin
      check("tbl_gnt", rd_gnt, v.e_gnt);
      check("tbl_valid", rd_valid, v.e_valid);
      check("tbl_perr", rd_perr, v.e_perr);
      if (v.chk_data) check("tbl_data", rd_data, v.e_data);
    end
    // Effect of the rising edge
    if (v.wr && v.waddr < D) begin
      m_mem[v.waddr]   = v.wdata;
      m_known[v.waddr] = 1'b1;
      m_inj[v.waddr]   = v.inj;
    end
    if (!v.rst_n) begin
      m_rr = 0;  m_pend = -1;  m_addr = 0;
    end else if (g >= 0) begin
      m_rr = (g + 1) % N;  m_pend = g;  m_addr = ra[g];
    end else begin
      m_pend = -1;
    end
    cyc++;
  endtask

  initial begin
    vec_t v;
    pass_cnt = 0;  total_cnt = 0;  cyc = 0;
    m_rr = 0;  m_pend = -1;  m_addr = 0;
    for (int i = 0; i < D; i++) begin
      m_known[i] = 1'b0;  m_inj[i] = 1'b0;  m_mem[i] = 8'h00;
    end
    rstN = 1'b0;  wr_en = 1'b0;  wr_addr = '0;  wr_data = '0;
    wr_perr_inject = 1'b0;  rd_req = '0;  rd_addr = '0;
    repeat (2) @(posedge clk);

    // Reset-state checks, then the loader fills the whole array.
    step(mk(0, 0, 0, 0, 0, 3, 1, 2, 0, 0, 0, 0, 0), 1'b1);
    for (int a = 0; a < D; a++)
      step(mk(1, 1, a, $urandom_range(0, 255), 1'($urandom_range(0, 1)),
              0, 0, 0, 0, 0, 0, 0, 0), 1'b0);

    //            rst wr  wa    wd   inj req a0   a1  gnt val cd  data  perr
    vecs[0]  = mk(0, 0,   0,    0,   0,  0,  0,   0,  0,  0,  0,  0,    0);
    vecs[1]  = mk(1, 1,   3, 'hA5,   0,  0,  0,   0,  0,  0,  0,  0,    0);
    vecs[2]  = mk(1, 1,   4, 'h5A,   0,  0,  0,   0,  0,  0,  0,  0,    0);
    vecs[3]  = mk(1, 0,   0,    0,   0,  1,  3,   0,  1,  0,  0,  0,    0);
    vecs[4]  = mk(1, 0,   0,    0,   0,  1,  4,   0,  1,  1,  1, 'hA5,  0);
    vecs[5]  = mk(1, 0,   0,    0,   0,  0,  0,   0,  0,  1,  1, 'h5A,  0);
    vecs[6]  = mk(1, 0,   0,    0,   0,  3,  5,   6,  2,  0,  0,  0,    0);
    vecs[7]  = mk(1, 0,   0,    0,   0,  3,  5,   6,  1,  2,  0,  0,    0);
    vecs[8]  = mk(1, 0,   0,    0,   0,  3,  5,   6,  2,  1,  0,  0,    0);
    vecs[9]  = mk(1, 0,   0,    0,   0,  2,  0,   7,  2,  2,  0,  0,    0);
    vecs[10] = mk(1, 0,   0,    0,   0,  2,  0,   7,  2,  2,  0,  0,    0);
    vecs[11] = mk(1, 1,  10, 'h3C,   0,  3,  9,  10,  0,  2,  0,  0,    0);
    vecs[12] = mk(1, 1,  11, 'h00,   0,  3,  9,  10,  0,  0,  0,  0,    0);
    vecs[13] = mk(1, 1, 250, 'hFF,   0,  3,  9,  10,  0,  0,  0,  0,    0);
    vecs[14] = mk(1, 0,   0,    0,   0,  3,  9,  10,  1,  0,  0,  0,    0);
    vecs[15] = mk(1, 0,   0,    0,   0,  2,  9,  10,  2,  1,  0,  0,    0);
    vecs[16] = mk(1, 0,   0,    0,   0,  1, 250,  0,  1,  2,  1, 'h3C,  0);
    vecs[17] = mk(1, 0,   0,    0,   0,  0,  0,   0,  0,  1,  1, 'h00,  0);
    vecs[18] = mk(1, 1,  20, 'hC3,   0,  0,  0,   0,  0,  0,  0,  0,    0);
    vecs[19] = mk(1, 0,   0,    0,   0,  2,  0,  20,  2,  0,  0,  0,    0);
    vecs[20] = mk(1, 1,  20, 'h11,   0,  0,  0,   0,  0,  2,  1, 'hC3,  0);
    vecs[21] = mk(1, 0,   0,    0,   0,  1, 20,   0,  1,  0,  0,  0,    0);
    vecs[22] = mk(1, 0,   0,    0,   0,  0,  0,   0,  0,  1,  1, 'h11,  0);
    vecs[23] = mk(0, 0,   0,    0,   0,  3,  3,   4,  0,  0,  0,  0,    0);
    vecs[24] = mk(1, 0,   0,    0,   0,  3,  3,   4,  1,  0,  0,  0,    0);
    vecs[25] = mk(1, 0,   0,    0,   0,  0,  0,   0,  0,  1,  1, 'hA5,  0);
    vecs[26] = mk(1, 1,  30, 'h0F,   1,  0,  0,   0,  0,  0,  0,  0,    0);
    vecs[27] = mk(1, 1,  31, 'h0F,   0,  0,  0,   0,  0,  0,  0,  0,    0);
    vecs[28] = mk(1, 0,   0,    0,   0,  1, 30,   0,  1,  0,  0,  0,    0);
    vecs[29] = mk(1, 0,   0,    0,   0,  1, 31,   0,  1,  1,  1, 'h0F, PAR_EN);
    vecs[30] = mk(1, 0,   0,    0,   0,  0,  0,   0,  0,  1,  1, 'h0F,  0);

    for (int i = 0; i < 31; i++) step(vecs[i], 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      v.rst_n = ($urandom_range(0, 63) != 0);
      v.wr    = v.rst_n && ($urandom_range(0, 7) == 0);
      v.waddr = 8'($urandom_range(0, 255));
      v.wdata = 8'($urandom_range(0, 255));
      v.inj   = 1'($urandom_range(0, 1));
      v.req   = 2'($urandom_range(0, 3));
      v.a0    = 8'($urandom_range(0, 219));
      v.a1    = 8'($urandom_range(0, 219));
      v.e_gnt = '0;  v.e_valid = '0;  v.chk_data = 1'b0;
      v.e_data = '0;  v.e_perr = 1'b0;
      step(v, 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
